// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side controller of an asynchronous FIFO.
// Brings the Gray read pointer into the WR_CLK domain through two flops.
// Keeps the binary and Gray write pointers, and derives full, fill level and
// almost-full from the synchronized read pointer. Because that pointer lags
// the real read side, full and level are pessimistic and never optimistic.
// Optional feature: define FIFO_WR_OVF_FLAG_EN to build the sticky overflow
// flag. Without it, WR_overflow is tied low and WR_ovf_clr is ignored.
module fifo_wr_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_DATA  = 3,
    parameter int AF_THRESH  = 6
) (
    input  logic                 WR_CLK,
    input  logic                 WR_RST,
    input  logic                 WR_inc,
    input  logic [ADDR_DATA:0]   RD_PTR_g,
    output logic                 WR_en,
    output logic [ADDR_DATA-1:0] WR_addr,
    output logic [ADDR_DATA:0]   WR_PTR_g,
    output logic                 WR_full,
    output logic                 WR_almost_full,
    output logic [ADDR_DATA:0]   WR_level,
    input  logic                 WR_ovf_clr,
    output logic                 WR_overflow
);

    // Full when the write pointer is exactly one lap ahead of the read pointer.
    // In Gray code, that means the two MSBs are inverted and the remaining bits are equal.
    localparam logic [ADDR_DATA:0] FULL_MASK = {2'b11, {(ADDR_DATA-1){1'b0}}};
    localparam logic [ADDR_DATA:0] AF_LVL    = (ADDR_DATA+1)'(AF_THRESH);

    logic [ADDR_DATA:0] sync1;
    logic [ADDR_DATA:0] sync2;
    logic [ADDR_DATA:0] wr_ptr;
    logic [ADDR_DATA:0] wr_ptr_nxt;
    logic [ADDR_DATA:0] wr_ptr_g_nxt;
    logic [ADDR_DATA:0] rd_ptr_bin;

    // DATA_WIDTH only sizes the shared memory. This controller never needs it.
    logic unused_ok;
    assign unused_ok = DATA_WIDTH[0];

    function automatic logic [ADDR_DATA:0] gray2bin(input logic [ADDR_DATA:0] g);
        logic [ADDR_DATA:0] b;
        b[ADDR_DATA] = g[ADDR_DATA];
        for (int i = ADDR_DATA - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Two-flop synchronizer for the read pointer coming from the other clock domain.
    always_ff @(posedge WR_CLK) begin
        if (WR_RST) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= RD_PTR_g;
            sync2 <= sync1;
        end
    end

    // Status is derived only from registered pointers.
    // A write is dropped while full or during reset.
    always_comb begin
        rd_ptr_bin     = gray2bin(sync2);
        WR_full        = (WR_PTR_g == (sync2 ^ FULL_MASK));
        WR_level       = wr_ptr - rd_ptr_bin;
        WR_almost_full = (WR_level >= AF_LVL);
        WR_en          = WR_inc & ~WR_full & ~WR_RST;
        WR_addr        = wr_ptr[ADDR_DATA-1:0];
        wr_ptr_nxt     = wr_ptr + {{ADDR_DATA{1'b0}}, WR_en};
        wr_ptr_g_nxt   = wr_ptr_nxt ^ (wr_ptr_nxt >> 1);
    end

    // The binary and Gray write pointers advance together, on the same edge.
    always_ff @(posedge WR_CLK) begin
        if (WR_RST) begin
            wr_ptr   <= '0;
            WR_PTR_g <= '0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            WR_PTR_g <= wr_ptr_g_nxt;
        end
    end

`ifdef FIFO_WR_OVF_FLAG_EN
    logic ovf_q;

    // Sticky overflow flag. A new overflow wins over a clear in the same cycle.
    always_ff @(posedge WR_CLK) begin
        if (WR_RST) begin
            ovf_q <= 1'b0;
        end else if (WR_inc && WR_full) begin
            ovf_q <= 1'b1;
        end else if (WR_ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign WR_overflow = ovf_q;
`else
    logic unused_clr;
    assign unused_clr  = WR_ovf_clr;
    assign WR_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Testbench for fifo_wr_ctrl with the default parameters (depth 8, almost-full at 6).
// The reference model tracks the write count, the read count and the read
// count as seen two edges later, all as plain integers.
module tb_fifo_wr_ctrl;

    logic       WR_CLK = 1'b0;
    logic       WR_RST;
    logic       WR_inc;
    logic [3:0] RD_PTR_g;
    logic       WR_en;
    logic [2:0] WR_addr;
    logic [3:0] WR_PTR_g;
    logic       WR_full;
    logic       WR_almost_full;
    logic [3:0] WR_level;
    logic       WR_ovf_clr;
    logic       WR_overflow;

    int checks   = 0;
    int failures = 0;

    // model state: write count, read count driven, read count seen after 1 and 2 edges
    int m_wr  = 0;
    int m_rd  = 0;
    int m_s1  = 0;
    int m_s2  = 0;
    bit m_ovf = 0;

    fifo_wr_ctrl #(.DATA_WIDTH(8), .ADDR_DATA(3), .AF_THRESH(6)) dut (
        .WR_CLK         (WR_CLK),
        .WR_RST         (WR_RST),
        .WR_inc         (WR_inc),
        .RD_PTR_g       (RD_PTR_g),
        .WR_en          (WR_en),
        .WR_addr        (WR_addr),
        .WR_PTR_g       (WR_PTR_g),
        .WR_full        (WR_full),
        .WR_almost_full (WR_almost_full),
        .WR_level       (WR_level),
        .WR_ovf_clr     (WR_ovf_clr),
        .WR_overflow    (WR_overflow)
    );

    always #5 WR_CLK = ~WR_CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int to_gray(input int b);
        return (b ^ (b >> 1)) & 15;
    endfunction

    function automatic int m_level();
        return (m_wr - m_s2) & 15;
    endfunction

    function automatic bit m_full();
        return m_level() == 8;
    endfunction

    task automatic check_outputs();
        int lvl;
        lvl = m_level();
        check_val("addr",   32'(WR_addr),        32'(m_wr & 7));
        check_val("ptr_g",  32'(WR_PTR_g),       32'(to_gray(m_wr)));
        check_val("full",   32'(WR_full),        32'(lvl == 8));
        check_val("level",  32'(WR_level),       32'(lvl));
        check_val("afull",  32'(WR_almost_full), 32'(lvl >= 6));
        check_val("ovf",    32'(WR_overflow),    32'(m_ovf));
    endtask

    // Called just after a falling edge. Drives one cycle, advances the model and checks outputs.
    task automatic cycle(input bit inc, input bit clr, input bit rst);
        bit full_b;
        bit en;
        WR_inc     = inc;
        WR_ovf_clr = clr;
        WR_RST     = rst;
        RD_PTR_g   = 4'(to_gray(m_rd));
        #1;
        full_b = m_full();
        en     = inc && !full_b && !rst;
        check_val("wr_en", 32'(WR_en), 32'(en));
        @(posedge WR_CLK);
        if (rst) begin
            m_wr  = 0;
            m_s1  = 0;
            m_s2  = 0;
            m_ovf = 0;
        end else begin
            m_s2 = m_s1;
            m_s1 = m_rd;
            m_wr = (m_wr + int'(en)) & 15;
`ifdef FIFO_WR_OVF_FLAG_EN
            if (inc && full_b)
                m_ovf = 1;
            else if (clr)
                m_ovf = 0;
`endif
        end
        @(negedge WR_CLK);
        check_outputs();
    endtask

    initial begin
        WR_RST     = 1'b1;
        WR_inc     = 1'b0;
        WR_ovf_clr = 1'b0;
        RD_PTR_g   = 4'd0;
        @(negedge WR_CLK);

        // reset with the read pointer at zero
        m_rd = 0;
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        check_val("rst_level", 32'(WR_level), 32'd0);
        check_val("rst_full",  32'(WR_full),  32'd0);

        // eight writes fill the FIFO
        for (int i = 0; i < 8; i++) cycle(1, 0, 0);
        check_val("full_after8", 32'(WR_full),  32'd1);
        check_val("ptr_g_full",  32'(WR_PTR_g), 32'b1100);
        check_val("addr_full",   32'(WR_addr),  32'd0);
        check_val("level_full",  32'(WR_level), 32'd8);

        // a write attempted while full is dropped; then clear the flag
        cycle(1, 0, 0);
        check_val("ptr_g_hold", 32'(WR_PTR_g), 32'b1100);
`ifdef FIFO_WR_OVF_FLAG_EN
        check_val("ovf_set", 32'(WR_overflow), 32'd1);
`else
        check_val("ovf_tied", 32'(WR_overflow), 32'd0);
`endif
        cycle(0, 1, 0);
        check_val("ovf_clr", 32'(WR_overflow), 32'd0);

        // one read: full drops only after the second edge
        m_rd = 1;
        cycle(0, 0, 0);
        check_val("full_lag1", 32'(WR_full), 32'd1);
        cycle(0, 0, 0);
        check_val("full_lag2", 32'(WR_full),  32'd0);
        check_val("level_7",   32'(WR_level), 32'd7);

        // reset, then 16 writes with the read pointer following each one
        m_rd = 0;
        cycle(0, 0, 1);
        for (int i = 0; i < 16; i++) begin
            cycle(1, 0, 0);
            m_rd = (m_rd + 1) & 15;
        end
        check_val("wrap_ptr_g", 32'(WR_PTR_g), 32'd0);
        check_val("wrap_addr",  32'(WR_addr),  32'd0);

        // reset in the middle of a burst
        for (int i = 0; i < 5; i++) cycle(1, 0, 0);
        m_rd = 0;
        cycle(1, 0, 1);
        check_val("burst_rst_ptr_g", 32'(WR_PTR_g), 32'd0);
        check_val("burst_rst_level", 32'(WR_level), 32'd0);
        check_val("burst_rst_addr",  32'(WR_addr),  32'd0);
        cycle(0, 0, 0);
        check_val("sync_cleared_level", 32'(WR_level), 32'd0);

        // randomized traffic, with the read side never passing the writes
        for (int i = 0; i < 600; i++) begin
            bit r_rst;
            bit r_inc;
            bit r_clr;
            r_rst = ($urandom_range(0, 59) == 0);
            r_inc = ($urandom_range(0, 9) < 7);
            r_clr = ($urandom_range(0, 7) == 0);
            if (r_rst)
                m_rd = 0;
            else if (($urandom_range(0, 1) == 1) && (((m_wr - m_rd) & 15) != 0))
                m_rd = (m_rd + 1) & 15;
            cycle(r_inc, r_clr, r_rst);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
